wb_imem_loader: RTL and testbench
=================================

# wb_imem_loader

Wishbone slave sitting between the user-project Wishbone port and the jacaranda-8 `computer` core, directly upstream of its instruction memory. Lets the management SoC load program bytes, read them back, and hold the CPU in reset while a program is loaded. Also exposes a small control/status register pair.

## Interface
- `BASE_ADDR`, 32'h3000_0000: Wishbone window base; only `wbs_adr_i[31:12]` is compared.
- `IMEM_AW`, 8: instruction memory address width, giving 256 bytes.
- `wb_clk_i` in 1: single clock for the whole block.
- `wb_rst_ni` in 1: asynchronous, active-low reset. The wrapper drives it from `~wb_rst_i`.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic cycle, strobe, write enable.
- `wbs_sel_i` in 4: byte selects; only `[0]` is meaningful.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: registered acknowledge.
- `wbs_dat_o` out 32: read data, zero-extended.
- `imem_we` out 1: one-cycle write strobe to the instruction memory.
- `imem_re` out 1: one-cycle read strobe; memory read is synchronous with 1-cycle latency.
- `imem_addr` out `IMEM_AW`: memory byte index.
- `imem_wdata` out 8: memory write data.
- `imem_rdata` in 8: memory read data, valid the cycle after `imem_re`.
- `cpu_rst_n` out 1: active-low reset to the `computer` core; equals `~hold`.

## Operation
- Address decode, with `off = wbs_adr_i[11:0]` and the request in window:
  - 0x000–0x3FC: IMEM. Byte index = `off[9:2]`; data lane = `[7:0]`.
  - 0x400: CTRL.
    - bit0 = `hold`, reset value 1.
    - bit1 = `clr`, write-1 pulse: clears `wr_cnt` and `err`. It reads as 0.
  - 0x404: STATUS (read-only).
    - `[8:0]` = `wr_cnt`.
    - `[16]` = `err`, sticky.
    - `[17]` = `hold`.
  - Other in-window offsets: reads return 0, writes are ignored, the access is still acked.
- Out-of-window requests are never acked and produce no memory strobe.
- FSM states:
  - IDLE:
    - Valid request with `cyc & stb` → ACK. An IMEM read instead goes → RD_WAIT.
    - An IMEM write with `sel[0]=1` pulses `imem_we` in the transition cycle.
    - An IMEM read pulses `imem_re` in the transition cycle.
  - RD_WAIT: captures `imem_rdata` into `wbs_dat_o[7:0]` → ACK. If `cyc` has dropped, go → IDLE with no ack.
  - ACK: `wbs_ack_o=1` for exactly one cycle → IDLE.
- IMEM write while `hold=0`:
  - No `imem_we`.
  - `err` is set.
  - The access is still acked.
- IMEM write with `sel[0]=0`: acked with no strobe, and `wr_cnt` is unchanged.
- `wr_cnt` increments once per performed IMEM write and saturates at 256.
- A CTRL write with `clr=1` in the same cycle as any other event: clear takes priority.
- Reset value of every output:
  - `wbs_ack_o=0`.
  - `wbs_dat_o=0`.
  - `imem_we=0`, `imem_re=0`.
  - `imem_addr=0`, `imem_wdata=0`.
  - `cpu_rst_n=0`: the CPU is held at reset.

## Timing
- Latency:
  - Write/register access: request seen in IDLE at cycle N; `wbs_ack_o` is high in cycle N+1.
  - IMEM read: `imem_re` in N, capture in N+1, ack in N+2.
- `imem_addr` and `imem_wdata` are stable in the cycle `imem_we` or `imem_re` is high.
- After an ack, the next request is sampled no earlier than one cycle later, because the FSM must return to IDLE first.
- `cpu_rst_n` changes in the cycle after the acked CTRL write.
- Asserting `wb_rst_ni` mid-transaction:
  - Returns the FSM to IDLE immediately.
  - Sets `hold=1` and clears `wr_cnt` and `err`.
  - No ack is issued for the interrupted access.
- `wbs_dat_o` is only meaningful while `wbs_ack_o=1`; it holds its last value otherwise.

## Configuration
- `WB_IMEM_LOADER_READBACK_EN` defined:
  - IMEM reads go through RD_WAIT and return memory contents.
  - `imem_re` is driven.
- Not defined:
  - IMEM reads are acked in one cycle with data 0.
  - `imem_re` is tied to 0.
  - No RD_WAIT state exists.

## Structure
- Package `wb_imem_loader_pkg` holds:
  - The FSM state enum (IDLE, RD_WAIT, ACK).
  - The offset constants `OFF_CTRL`=12'h400 and `OFF_STATUS`=12'h404.
  - The STATUS bit positions.
- One sub-module, `wb_imem_loader_csr`:
  - Holds `hold`, `err` and `wr_cnt`.
  - Handles the clear-priority and saturation logic.
  - Drives `cpu_rst_n`.
- The top level contains the decode and the FSM.

## Test plan
- Reset release → `cpu_rst_n=0`, `wbs_ack_o=0`; STATUS read returns 0x0002_0000.
- Write 0xA5 at 0x3000_0010 with `hold=1` → `imem_we` pulse with addr 0x04 and data 0xA5; ack next cycle; `wr_cnt=1`.
- Write CTRL=0, then an IMEM write → no `imem_we`; ack still given; STATUS bit16=1; `cpu_rst_n=1`.
- With READBACK_EN, read 0x3000_0010 → `imem_re` in N; ack in N+2 with `wbs_dat_o=0x0000_00A5`. Without READBACK_EN → ack in N+1 with data 0.
- 257 IMEM writes then a STATUS read → `[8:0]=256`. A CTRL write of 0x3 → `wr_cnt=0`, `err=0`.
- Access to 0x3000_1000 → no ack within 8 cycles. Asserting `wb_rst_ni` during RD_WAIT → FSM returns to IDLE, no ack, `cpu_rst_n=0`.

Source files
------------

// File: rtl/wb_imem_loader_pkg.sv
// Shared constants for the Wishbone instruction-memory loader: FSM encoding,
// register offsets and CTRL/STATUS bit layout. Build option: WB_IMEM_LOADER_READBACK_EN.
package wb_imem_loader_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
`ifdef WB_IMEM_LOADER_READBACK_EN
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
`endif
    localparam logic [1:0] ST_ACK     = 2'd2;

    localparam logic [11:0] OFF_CTRL   = 12'h400;
    localparam logic [11:0] OFF_STATUS = 12'h404;

    localparam int CTRL_HOLD_BIT = 0;
    localparam int CTRL_CLR_BIT  = 1;

    localparam int STS_CNT_MSB  = 8;
    localparam int STS_ERR_BIT  = 16;
    localparam int STS_HOLD_BIT = 17;

    function automatic logic [31:0] status_word(input logic hold, input logic err,
                                                input logic [STS_CNT_MSB:0] cnt);
        logic [31:0] w;
        w = '0;
        w[STS_CNT_MSB:0]  = cnt;
        w[STS_ERR_BIT]    = err;
        w[STS_HOLD_BIT]   = hold;
        return w;
    endfunction

    // clr is a pulse, so only hold is visible on readback
    function automatic logic [31:0] ctrl_word(input logic hold);
        logic [31:0] w;
        w = '0;
        w[CTRL_HOLD_BIT] = hold;
        return w;
    endfunction

endpackage

// File: rtl/wb_imem_loader_if.sv
// Wishbone classic slave-port bundle between the user-project bus and the loader.
// Build option: WB_IMEM_LOADER_READBACK_EN (no effect on this interface).
interface wb_imem_loader_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_imem_loader_csr.sv
// CPU-hold, sticky error and saturating write counter behind the CTRL/STATUS pair.
// Build option: WB_IMEM_LOADER_READBACK_EN (no effect on this module).
module wb_imem_loader_csr
    import wb_imem_loader_pkg::*;
(
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 ctrl_we,
    input  logic [1:0]           ctrl_wdata,
    input  logic                 wr_done,
    input  logic                 wr_blocked,
    output logic                 hold,
    output logic                 err,
    output logic [STS_CNT_MSB:0] wr_cnt,
    output logic                 cpu_rst_n
);
    logic                 hold_q, hold_d;
    logic                 err_q, err_d;
    logic [STS_CNT_MSB:0] cnt_q, cnt_d;

    always_comb begin
        hold_d = hold_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (wr_done && cnt_q != 9'd256) cnt_d = cnt_q + 9'd1;
        if (wr_blocked) err_d = 1'b1;
        // clear is applied last so it wins over a same-cycle increment or error
        if (ctrl_we) begin
            hold_d = ctrl_wdata[CTRL_HOLD_BIT];
            if (ctrl_wdata[CTRL_CLR_BIT]) begin
                cnt_d = '0;
                err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            hold_q <= 1'b1;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hold_q <= hold_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hold      = hold_q;
    assign err       = err_q;
    assign wr_cnt    = cnt_q;
    assign cpu_rst_n = ~hold_q;
endmodule

// File: rtl/wb_imem_loader.sv
// Wishbone slave that loads/reads the jacaranda-8 instruction memory and holds the CPU
// in reset while loading. Build option: WB_IMEM_LOADER_READBACK_EN enables IMEM readback.
module wb_imem_loader
    import wb_imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IMEM_AW   = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_imem_loader_if.slave    wbs,
    output logic               imem_we,
    output logic               imem_re,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [7:0]         imem_wdata,
    input  logic [7:0]         imem_rdata,
    output logic               cpu_rst_n
);
    logic [1:0]           state_q, state_d;
    logic [31:0]          dat_q, dat_d;
    logic                 hold, err;
    logic [STS_CNT_MSB:0] wr_cnt;
    logic                 ctrl_we, wr_done, wr_blocked, re_d;
    logic [11:0]          off;
    logic                 in_win, req, is_imem;
    logic [IMEM_AW-1:0]   idx;
    logic                 unused_bits;

    assign off     = wbs.wbs_adr_i[11:0];
    assign in_win  = wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12];
    assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & in_win;
    assign is_imem = off[11:10] == 2'b00;
    assign idx     = wbs.wbs_adr_i[IMEM_AW+1:2];

    always_comb begin
        state_d    = state_q;
        dat_d      = dat_q;
        ctrl_we    = 1'b0;
        wr_done    = 1'b0;
        wr_blocked = 1'b0;
        re_d       = 1'b0;
        case (state_q)
            ST_IDLE: if (req) begin
                state_d = ST_ACK;
                if (wbs.wbs_we_i) begin
                    if (is_imem && wbs.wbs_sel_i[0]) begin
                        wr_done    = hold;
                        wr_blocked = ~hold;
                    end
                    ctrl_we = (off == OFF_CTRL) && wbs.wbs_sel_i[0];
                end else if (is_imem) begin
`ifdef WB_IMEM_LOADER_READBACK_EN
                    re_d    = 1'b1;
                    state_d = ST_RD_WAIT;
`else
                    dat_d   = '0;
`endif
                end else if (off == OFF_CTRL) begin
                    dat_d = ctrl_word(hold);
                end else if (off == OFF_STATUS) begin
                    dat_d = status_word(hold, err, wr_cnt);
                end else begin
                    dat_d = '0;
                end
            end
`ifdef WB_IMEM_LOADER_READBACK_EN
            // master abandoned the read: drop it silently rather than ack a dead cycle
            ST_RD_WAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    dat_d   = {24'b0, imem_rdata};
                    state_d = ST_ACK;
                end
            end
`endif
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
        end
    end

    wb_imem_loader_csr u_csr (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .ctrl_we    (ctrl_we),
        .ctrl_wdata (wbs.wbs_dat_i[1:0]),
        .wr_done    (wr_done),
        .wr_blocked (wr_blocked),
        .hold       (hold),
        .err        (err),
        .wr_cnt     (wr_cnt),
        .cpu_rst_n  (cpu_rst_n)
    );

    assign wbs.wbs_ack_o = (state_q == ST_ACK);
    assign wbs.wbs_dat_o = dat_q;

    // address/data are forced to zero outside a strobe so the memory bus stays quiet
    assign imem_we    = wr_done;
    assign imem_re    = re_d;
    assign imem_addr  = (wr_done | re_d) ? idx : '0;
    assign imem_wdata = wr_done ? wbs.wbs_dat_i[7:0] : 8'h00;

`ifdef WB_IMEM_LOADER_READBACK_EN
    assign unused_bits = ^{wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:8], wbs.wbs_adr_i[1:0]};
`else
    assign unused_bits = ^{wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:8], wbs.wbs_adr_i[1:0],
                           imem_rdata};
`endif
endmodule

// File: tb/tb_wb_imem_loader.sv
// Randomized scoreboard bench for wb_imem_loader against a register/memory-level model.
// Honors WB_IMEM_LOADER_READBACK_EN the same way as the design.
module tb_wb_imem_loader;
    import wb_imem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_imem_loader_if bus ();
    logic       imem_we, imem_re, cpu_rst_n;
    logic [7:0] imem_addr, imem_wdata;
    logic [7:0] imem_rdata = 8'h00;
    logic [7:0] mem [256] = '{default: 8'h00};

    wb_imem_loader #(.BASE_ADDR(32'h3000_0000), .IMEM_AW(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs        (bus),
        .imem_we    (imem_we),
        .imem_re    (imem_re),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_rdata (imem_rdata),
        .cpu_rst_n  (cpu_rst_n)
    );

    // synchronous 1-cycle-latency instruction memory
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        if (imem_re) imem_rdata <= mem[imem_addr];
    end

    typedef struct packed {logic is_rd; logic [31:0] dat;} ack_t;
    ack_t        ack_q[$];
    logic [15:0] we_q[$];
    logic [7:0]  re_q[$];

    // reference model state
    bit         mdl_hold = 1'b1;
    bit         mdl_err  = 1'b0;
    int         mdl_cnt  = 0;
    logic [7:0] mdl_mem [256] = '{default: 8'h00};

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops expected responses whenever the DUT presents an ack or a strobe
    always @(negedge clk) begin : monitor
        ack_t        e;
        logic [15:0] w;
        logic [7:0]  r;
        if (rst_n) begin
            if (bus.wbs_ack_o) begin
                if (ack_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
                else begin
                    e = ack_q.pop_front();
                    if (e.is_rd) chk("rd_data", bus.wbs_dat_o, e.dat);
                end
            end
            if (imem_we) begin
                if (we_q.size() == 0) chk("unexpected_imem_we", {imem_addr, imem_wdata}, 32'hDEAD);
                else begin
                    w = we_q.pop_front();
                    chk("imem_we_addr_data", {16'b0, imem_addr, imem_wdata}, {16'b0, w});
                end
            end
            if (imem_re) begin
                if (re_q.size() == 0) chk("unexpected_imem_re", {24'b0, imem_addr}, 32'hDEAD);
                else begin
                    r = re_q.pop_front();
                    chk("imem_re_addr", {24'b0, imem_addr}, {24'b0, r});
                end
            end
        end
    end

    function automatic logic [31:0] mdl_status();
        return {14'b0, mdl_hold, mdl_err, 7'b0, 9'(mdl_cnt)};
    endfunction

    task automatic access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
        int         exp_lat;
        int         k;
        bit         got;
        logic [11:0] off;
        logic [7:0] ix;
        ack_t       e;
        off = adr[11:0];
        ix  = off[9:2];
        exp_lat = 0;
        if (adr[31:12] == 20'h30000) begin
            exp_lat = 1;
            e.is_rd = !we;
            e.dat   = 32'h0;
            if (we) begin
                if (off < 12'h400) begin
                    if (sel[0]) begin
                        if (mdl_hold) begin
                            we_q.push_back({ix, dat[7:0]});
                            mdl_mem[ix] = dat[7:0];
                            if (mdl_cnt < 256) mdl_cnt++;
                        end else mdl_err = 1'b1;
                    end
                end else if (off == OFF_CTRL && sel[0]) begin
                    if (dat[1]) begin
                        mdl_cnt = 0;
                        mdl_err = 1'b0;
                    end
                    mdl_hold = dat[0];
                end
            end else begin
                if (off < 12'h400) begin
`ifdef WB_IMEM_LOADER_READBACK_EN
                    exp_lat = 2;
                    re_q.push_back(ix);
                    e.dat = {24'b0, mdl_mem[ix]};
`endif
                end else if (off == OFF_CTRL) e.dat = {31'b0, mdl_hold};
                else if (off == OFF_STATUS) e.dat = mdl_status();
            end
            ack_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
        got = 1'b0;
        k = 0;
        while (k < 8 && !got) begin
            @(negedge clk);
            k++;
            if (bus.wbs_ack_o) got = 1'b1;
        end
        if (exp_lat == 0) chk("no_ack_out_of_window", {31'b0, got}, 32'd0);
        else begin
            chk("ack_latency", k, exp_lat + 1);
            if (!got) ack_q.delete();
        end
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        chk("cpu_rst_n", {31'b0, cpu_rst_n}, {31'b0, !mdl_hold});
    endtask

    // reset asserted while a read is outstanding must kill it without an ack
    task automatic reset_mid();
        logic [31:0] adr;
`ifdef WB_IMEM_LOADER_READBACK_EN
        adr = 32'h3000_0010;
        re_q.push_back(8'h04);
`else
        adr = 32'h3000_0404;
`endif
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = adr;  bus.wbs_sel_i = 4'hF;
        @(negedge clk);
`ifdef WB_IMEM_LOADER_READBACK_EN
        @(posedge clk); #1;
`endif
        rst_n = 1'b0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        mdl_hold = 1'b1; mdl_err = 1'b0; mdl_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
            chk("rst_mid_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        end
    endtask

    initial begin
        int          kind;
        logic [31:0] d;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        chk("rst_dat", bus.wbs_dat_o, 32'd0);
        chk("rst_we_re", {30'b0, imem_we, imem_re}, 32'd0);
        chk("rst_addr_wdata", {16'b0, imem_addr, imem_wdata}, 32'd0);
        chk("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // directed walk through the register map
        access(0, 32'h3000_0404, 0, 4'hF);
        access(1, 32'h3000_0010, 32'h0000_00A5, 4'h1);
        access(0, 32'h3000_0404, 0, 4'hF);
        access(0, 32'h3000_0010, 0, 4'hF);
        access(1, 32'h3000_0400, 32'h0, 4'hF);
        access(1, 32'h3000_0020, 32'h5A, 4'h1);
        access(0, 32'h3000_0404, 0, 4'hF);
        access(0, 32'h3000_0400, 0, 4'hF);
        access(1, 32'h3000_0400, 32'h1, 4'hF);
        access(1, 32'h3000_0030, 32'h77, 4'hE);
        access(1, 32'h3000_1000, 32'h11, 4'hF);
        access(0, 32'h3000_1000, 0, 4'hF);
        access(1, 32'h2000_0010, 32'h22, 4'hF);
        access(0, 32'h3000_0800, 0, 4'hF);
        access(1, 32'h3000_0408, 32'hFFFF_FFFF, 4'hF);
        access(0, 32'h3000_0404, 0, 4'hF);

        // counter saturation and clear
        access(1, 32'h3000_0400, 32'h3, 4'hF);
        for (int i = 0; i < 257; i++)
            access(1, 32'h3000_0000 + 32'(4 * (i % 256)), $urandom, 4'h1);
        access(0, 32'h3000_0404, 0, 4'hF);
        access(1, 32'h3000_0400, 32'h3, 4'hF);
        access(0, 32'h3000_0404, 0, 4'hF);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 9);
            d = $urandom;
            case (kind)
                0, 1, 2, 3: access(1, 32'h3000_0000 + 32'(4 * $urandom_range(0, 255)), d,
                                   mdl_hold ? 4'($urandom) : 4'hF);
                4, 5:       access(0, 32'h3000_0000 + 32'(4 * $urandom_range(0, 255)), 0, 4'hF);
                6:          access(1, 32'h3000_0400,
                                   {30'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)},
                                   4'hF);
                7:          access(0, 32'h3000_0404, 0, 4'hF);
                8:          access(0, 32'h3000_0400, 0, 4'hF);
                default:    access(d[0], (d[1] ? 32'h3000_0000 : 32'h3100_0000) +
                                   32'h408 + 32'(4 * $urandom_range(0, 700)), d, 4'hF);
            endcase
        end

        // dirty the CSRs, then reset in the middle of a read
        access(1, 32'h3000_0400, 32'h0, 4'hF);
        access(1, 32'h3000_0040, 32'h33, 4'h1);
        reset_mid();
        access(0, 32'h3000_0404, 0, 4'hF);

        repeat (2) @(negedge clk);
        chk("ack_queue_drained", ack_q.size(), 32'd0);
        chk("we_queue_drained", we_q.size(), 32'd0);
        chk("re_queue_drained", re_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
